// File: rtl/intersection_phase_scheduler.sv
// Two-approach demand-actuated signal controller: green/yellow/all-red sequencing on a 1 Hz tick.
// Optional emergency preemption (emg_a/emg_b) is built when EMERGENCY_PREEMPT_EN is defined.
module intersection_phase_scheduler #(
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 60,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2,
  parameter int CW        = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          sens_a,
  input  logic          sens_b,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic          emg_a,
  input  logic          emg_b,
`endif
  output logic          a_r,
  output logic          a_y,
  output logic          a_g,
  output logic          b_r,
  output logic          b_y,
  output logic          b_g,
  output logic [2:0]    phase,
  output logic [CW-1:0] tmr,
  output logic          dem_a,
  output logic          dem_b
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0, A_YEL = 3'd1, AR_AB = 3'd2,
    B_GRN = 3'd3, B_YEL = 3'd4, AR_BA = 3'd5
  } state_t;

  localparam logic [CW-1:0] G_MIN = CW'(GREEN_MIN);
  localparam logic [CW-1:0] G_MAX = CW'(GREEN_MAX);
  localparam logic [CW-1:0] Y_T   = CW'(YELLOW_T);
  localparam logic [CW-1:0] R_T   = CW'(ALLRED_T);
  localparam logic [CW-1:0] ONE   = CW'(1);

  state_t        state, nxt;
  logic [CW-1:0] tmr_n, e;
  logic          dem_a_n, dem_b_n, exit_a, exit_b;
  logic          hold_a, go_a, hold_b, go_b;

  assign phase = state;

  // A wins a simultaneous request: it holds A green and forces B out.
`ifdef EMERGENCY_PREEMPT_EN
  assign hold_a = emg_a;
  assign go_a   = emg_b & ~emg_a;
  assign go_b   = emg_a;
  assign hold_b = emg_b & ~emg_a;
`else
  assign hold_a = 1'b0;
  assign go_a   = 1'b0;
  assign go_b   = 1'b0;
  assign hold_b = 1'b0;
`endif

  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      A_GRN:   lamps_of = 6'b001_100;
      A_YEL:   lamps_of = 6'b010_100;
      B_GRN:   lamps_of = 6'b100_001;
      B_YEL:   lamps_of = 6'b100_010;
      default: lamps_of = 6'b100_100;
    endcase
  endfunction

  always_comb begin
    nxt    = state;
    tmr_n  = tmr;
    e      = (tmr >= G_MAX) ? tmr : tmr + ONE;
    exit_a = go_a | (~hold_a & dem_b & ((e >= G_MAX) | ((e >= G_MIN) & ~sens_a)));
    exit_b = go_b | (~hold_b & dem_a & ((e >= G_MAX) | ((e >= G_MIN) & ~sens_b)));
    case (state)
      A_GRN: if (tick) begin
        if (exit_a) begin nxt = A_YEL; tmr_n = Y_T; end
        else tmr_n = e;
      end
      A_YEL: if (tick) begin
        if (tmr <= ONE) begin nxt = AR_AB; tmr_n = R_T; end
        else tmr_n = tmr - ONE;
      end
      AR_AB: if (tick) begin
        if (tmr <= ONE) begin nxt = B_GRN; tmr_n = '0; end
        else tmr_n = tmr - ONE;
      end
      B_GRN: if (tick) begin
        if (exit_b) begin nxt = B_YEL; tmr_n = Y_T; end
        else tmr_n = e;
      end
      B_YEL: if (tick) begin
        if (tmr <= ONE) begin nxt = AR_BA; tmr_n = R_T; end
        else tmr_n = tmr - ONE;
      end
      AR_BA: if (tick) begin
        if (tmr <= ONE) begin nxt = A_GRN; tmr_n = '0; end
        else tmr_n = tmr - ONE;
      end
      default: begin nxt = AR_BA; tmr_n = R_T; end
    endcase
    // Clearing on green entry wins over a same-cycle set.
    dem_a_n = ((nxt == A_GRN) && (state != A_GRN)) ? 1'b0
            : (dem_a | (sens_a & (state != A_GRN)));
    dem_b_n = ((nxt == B_GRN) && (state != B_GRN)) ? 1'b0
            : (dem_b | (sens_b & (state != B_GRN)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= A_GRN;
      tmr   <= '0;
      dem_a <= 1'b0;
      dem_b <= 1'b0;
      {a_r, a_y, a_g, b_r, b_y, b_g} <= 6'b001_100;
    end else begin
      state <= nxt;
      tmr   <= tmr_n;
      dem_a <= dem_a_n;
      dem_b <= dem_b_n;
      {a_r, a_y, a_g, b_r, b_y, b_g} <= lamps_of(nxt);
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with default timing (10/60/5/2).
module tb_intersection_phase_scheduler;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, sens_a = 1'b0, sens_b = 1'b0;
  logic a_r, a_y, a_g, b_r, b_y, b_g, dem_a, dem_b;
  logic [2:0] phase;
  logic [5:0] tmr;
`ifdef EMERGENCY_PREEMPT_EN
  logic emg_a = 1'b0, emg_b = 1'b0;
`endif
  int ntest = 0, nfail = 0;

  intersection_phase_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick), .sens_a(sens_a), .sens_b(sens_b),
`ifdef EMERGENCY_PREEMPT_EN
    .emg_a(emg_a), .emg_b(emg_b),
`endif
    .a_r(a_r), .a_y(a_y), .a_g(a_g), .b_r(b_r), .b_y(b_y), .b_g(b_g),
    .phase(phase), .tmr(tmr), .dem_a(dem_a), .dem_b(dem_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each tick is one strobed cycle followed by one quiet cycle; returns at a negedge.
  task automatic do_ticks(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  function automatic int lamps();
    return int'({a_r, a_y, a_g, b_r, b_y, b_g});
  endfunction

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("rst_phase", phase, 0);
    chk("rst_lamps", lamps(), 6'b001100);
    chk("rst_tmr", tmr, 0);
    chk("rst_dem", {dem_a, dem_b}, 0);

    // Rest in A green with no demand
    bad = 0;
    repeat (100) begin
      do_ticks(1);
      if (phase != 3'd0 || lamps() != 6'b001100) bad++;
    end
    chk("rest_green", bad, 0);
    chk("rest_tmr_sat", tmr, 60);

    // Demand arriving after saturation exits on the next tick
    @(negedge clk); sens_b = 1'b1;
    @(negedge clk); sens_b = 1'b0; sens_a = 1'b1;
    chk("dem_b_latch", dem_b, 1);
    do_ticks(1);
    chk("sat_exit_phase", phase, 1);
    chk("a_yel_tmr", tmr, 5);
    chk("a_yel_lamps", lamps(), 6'b010100);
    do_ticks(4);
    chk("a_yel_last", {29'd0, phase} * 100 + tmr, 101);
    do_ticks(1);
    chk("ar_ab_phase", phase, 2);
    chk("ar_ab_tmr", tmr, 2);
    chk("ar_ab_lamps", lamps(), 6'b100100);
    sens_b = 1'b1;
    do_ticks(2);
    chk("b_grn_phase", phase, 3);
    chk("b_grn_lamps", lamps(), 6'b100001);
    chk("b_grn_tmr", tmr, 0);
    chk("dem_b_clear_wins", dem_b, 0);
    chk("dem_a_set", dem_a, 1);

    // Gap-out on B at tick 15
    do_ticks(14);
    chk("b_hold_14", {29'd0, phase} * 100 + tmr, 314);
    sens_b = 1'b0;
    do_ticks(1);
    chk("gapout_phase", phase, 4);
    chk("b_yel_lamps", lamps(), 6'b100010);
    do_ticks(5);
    chk("ar_ba", {29'd0, phase} * 100 + tmr, 502);
    do_ticks(2);
    chk("back_a_grn", {29'd0, phase} * 100 + tmr, 0);
    chk("dem_a_clear", dem_a, 0);

    // Max-out with sens_a held
    @(negedge clk); sens_b = 1'b1;
    @(negedge clk); sens_b = 1'b0;
    do_ticks(59);
    chk("maxout_59", {29'd0, phase} * 100 + tmr, 59);
    do_ticks(1);
    chk("maxout_60", {29'd0, phase} * 100 + tmr, 105);
    do_ticks(7);
    chk("maxout_b_grn", {29'd0, phase} * 100 + tmr, 300);

    // No tick means no progress
    repeat (10) @(negedge clk);
    chk("no_tick_hold", {29'd0, phase} * 100 + tmr, 300);

    // GREEN_MIN boundary on B
    do_ticks(9);
    chk("min_9", {29'd0, phase} * 100 + tmr, 309);
    do_ticks(1);
    chk("min_10_exit", {29'd0, phase} * 100 + tmr, 405);

    // Reset in the middle of B yellow
    do_ticks(2);
    chk("b_yel_tmr3", {29'd0, phase} * 100 + tmr, 403);
    reset = 1'b0; sens_a = 1'b0;
    @(negedge clk);
    chk("midrst_state", {29'd0, phase} * 100 + tmr, 0);
    chk("midrst_lamps", lamps(), 6'b001100);
    chk("midrst_dem", {dem_a, dem_b}, 0);
    reset = 1'b1;

`ifdef EMERGENCY_PREEMPT_EN
    do_ticks(2);
    chk("emg_pre", {29'd0, phase} * 100 + tmr, 2);
    emg_b = 1'b1; sens_a = 1'b1;
    do_ticks(1);
    chk("emg_yel", {29'd0, phase} * 100 + tmr, 105);
    do_ticks(7);
    chk("emg_b_grn", phase, 3);
    bad = 0;
    repeat (100) begin
      do_ticks(1);
      if (phase != 3'd3) bad++;
    end
    chk("emg_hold", bad, 0);
    emg_b = 1'b0;
    do_ticks(1);
    chk("emg_release", phase, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Two-approach intersection controller: decides which road (A or B) holds green, and sequences green -> yellow -> all-red -> other green.
- Demand-actuated: latches car-sensor requests, enforces min/max green, rests in green when the other road is idle.
- Time base is an external 1-per-second `tick` strobe. The block drives both light heads directly and exposes phase/timer status to the display logic.

Parameters:
- GREEN_MIN, 10, minimum green length in ticks (>=1)
- GREEN_MAX, 60, maximum green length in ticks when the other road is waiting (>= GREEN_MIN)
- YELLOW_T, 5, yellow length in ticks (>=1)
- ALLRED_T, 2, all-red clearance in ticks (>=1)
- CW, 6, timer/counter width; must hold GREEN_MAX

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low (0 = reset), sampled on clk rising edge
- tick  in  1  one-cycle time-base strobe; all timing advances only on tick
- sens_a  in  1  vehicle present on road A (level)
- sens_b  in  1  vehicle present on road B (level)
- a_r, a_y, a_g  out  1 each  road A lamps, one-hot
- b_r, b_y, b_g  out  1 each  road B lamps, one-hot
- phase  out  3  current state encoding (see Behaviour)
- tmr  out  CW  ticks remaining in a timed state; green elapsed count in green states
- dem_a, dem_b  out  1 each  latched demand flags

Behaviour:
- States, with `phase` encoding:
  - A_GRN=0: a_g, b_r
  - A_YEL=1: a_y, b_r
  - AR_AB=2: a_r, b_r
  - B_GRN=3: b_g, a_r
  - B_YEL=4: b_y, a_r
  - AR_BA=5: a_r, b_r
  - Codes 6/7 are illegal and go to AR_BA next cycle.
- All outputs are registered, with no combinational input-to-output path.
- Reset (reset==0 at clk edge):
  - state=A_GRN, tmr=0, dem_a=dem_b=0.
  - Outputs next cycle: a_g=1, b_r=1, all other lamps 0, phase=0.
  - Reset mid-operation aborts immediately. No yellow is driven on the way.
- Demand latch:
  - dem_x is set on any cycle where sens_x=1 and road x is not green.
  - dem_x is cleared on the cycle the FSM enters X_GRN.
  - If set and clear occur in the same cycle, clear wins. This is safe because road x is green from that point on.
- Green states:
  - tmr=elapsed count. It is 0 on entry, increments on tick and saturates at GREEN_MAX.
  - On a tick, let e=tmr+1 (saturated). Leave X_GRN for X_YEL when dem_other=1 AND either:
    - e>=GREEN_MAX, or
    - e>=GREEN_MIN and sens_x=0 (gap-out).
  - If dem_other=0, stay in X_GRN indefinitely (rest in green).
  - If demand arrives after tmr has saturated at GREEN_MAX, the exit happens on the next tick.
- Timed states (YEL, AR):
  - On entry, tmr is loaded with the duration (YELLOW_T or ALLRED_T).
  - tmr decrements on each tick. On the tick where tmr==1, the FSM moves to the next state and loads that state's value.
  - Each timed state therefore lasts exactly N ticks.
- Transition order: A_YEL->AR_AB->B_GRN->B_YEL->AR_BA->A_GRN.
- Without tick, no state or timer changes. Demand latching continues regardless of tick.
- Safety invariant: a_g/a_y and b_g/b_y are never both non-red in the same cycle.

Optional Feature:
- EMERGENCY_PREEMPT_EN defined: adds inputs emg_a, emg_b (1 bit each, level).
  - If emg_x=1 while the other road is green, the FSM goes to yellow on the next tick, ignoring GREEN_MIN and demand. Yellow and all-red then run normally, ending in X_GRN.
  - While emg_x=1 in X_GRN, the FSM holds green with no max-out.
  - If emg_a and emg_b are asserted together, A has priority.
  - Emergency requests raised during yellow or all-red do not shorten those states.
- Not defined: ports absent, behaviour exactly as above.

Test Plan:
- Reset held low 3 cycles, then released, no sensors, 100 ticks -> a_g=1, b_r=1, phase=0 throughout; tmr saturates at 60.
- sens_b pulsed at tick 3, sens_a=0 -> A_YEL after tick 10, AR_AB after 5 more ticks, B_GRN after 2 more; dem_b clears on B_GRN entry.
- sens_a=1 constant, sens_b pulse at tick 0 -> A green holds exactly 60 ticks, then yellow 5, all-red 2, B_GRN.
- In B_GRN with dem_a set, sens_b drops at tick 15 -> B_YEL on that tick; full cycle returns to A_GRN after 5+2 ticks.
- reset=0 asserted mid B_YEL (tmr=3) -> next cycle a_g=1, b_r=1, tmr=0, demands cleared.
- EMERGENCY_PREEMPT_EN: in A_GRN at tmr=2, raise emg_b -> A_YEL on next tick (no GREEN_MIN wait); B_GRN held 100 ticks while emg_b=1.
